axis_output_packer: RTL and testbench
=====================================

Name: axis_output_packer

Overview:
- Sits directly downstream of the transmission-estimation / scene-recovery stage.
- Accepts its per-pixel dehazed RGB output and buffers it in a small FIFO.
- Presents it as a fully compliant AXI4-Stream master with TLAST at end-of-line, TUSER at start-of-frame, and correct TREADY backpressure.
- Supplies an almost-full ready signal so the top level can throttle the input stream. This replaces the current direct TREADY pass-through.

Parameters:
- IMG_WIDTH, 512: pixels per line.
- IMG_HEIGHT, 512: lines per frame.
- FIFO_DEPTH, 16: entries; must be a power of two, 4..256.
- AFULL_MARGIN, 4: free-slot threshold. Covers upstream pipeline latency; must be < FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pix_valid  in  1  dehazed pixel present this cycle
- pix_r  in  8  red
- pix_g  in  8  green
- pix_b  in  8  blue
- upstream_ready  out  1  registered; 1 when free slots > AFULL_MARGIN
- M_AXIS_TDATA  out  32  {8'h00, R, G, B}
- M_AXIS_TVALID  out  1  output word valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  last pixel of a line
- M_AXIS_TUSER  out  1  first pixel of a frame
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0, including upstream_ready.
  - FIFO pointers, count, col and row counters are 0.
  - upstream_ready rises on the first cycle after rst deasserts.
  - Reset mid-frame discards all FIFO contents and counters. Any partially transmitted frame is abandoned, with no TLAST emitted.
- Write side:
  - pix_valid=1 is a push. There is no handshake back, because the producer cannot stall.
  - Each entry is 27 bits: {eof, eol, sof, R, G, B}, tagged from the write-side counters.
    - sof = (col==0 && row==0)
    - eol = (col==IMG_WIDTH-1)
    - eof = eol && (row==IMG_HEIGHT-1)
  - col increments on every push. At IMG_WIDTH-1 it wraps to 0 and row increments. row wraps to 0 after IMG_HEIGHT-1.
- Overflow:
  - A push while count==FIFO_DEPTH with no simultaneous pop drops the pixel and sets overflow (held until rst).
  - col/row still advance on a dropped pixel, so geometry stays aligned.
- Read side (first-word-fall-through):
  - M_AXIS_TVALID = (count != 0).
  - TDATA, TLAST and TUSER come from the head entry.
  - A pop occurs when TVALID && TREADY.
  - While TVALID=1 and TREADY=0, all M_AXIS outputs hold stable.
- Latency: a push in cycle N into an empty FIFO gives TVALID=1 in cycle N+1 (registered storage and count).
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the push is accepted, not dropped, because the pop frees a slot in the same cycle.
  - When empty, there is no pop, since TVALID=0. The count becomes 1.
- frame_done: asserted in cycle N+1 when the popped entry has eof=1 in cycle N.
- upstream_ready: registered from next-cycle count; equals (FIFO_DEPTH - count_next) > AFULL_MARGIN.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package (haze_pkg) holds:
  - PIXEL_W=24, the entry field offsets (SOF_BIT=24, EOL_BIT=25, EOF_BIT=26) and ENTRY_W=27.
  - A clog2 function.
  - Default IMG_WIDTH and IMG_HEIGHT constants shared with the window generator.
- One sub-module: sync_fifo_fwft, a parameterised width/depth synchronous FWFT FIFO.
  - Provides push, pop, full, empty and count.
  - Has no drop logic; overflow policy lives in the parent.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, TREADY=1, 8 consecutive pushes of R=G=B=i (i=0..7):
  - TDATA is 0x00_000000 through 0x00_070707, each one cycle after its push.
  - TUSER=1 on word 0 only; TLAST=1 on words 3 and 7.
  - frame_done pulses one cycle after word 7; the pattern repeats cleanly on a second frame.
- TREADY=0 for 20 cycles with FIFO_DEPTH=16 and continuous pushes:
  - upstream_ready falls when count reaches 12.
  - count saturates at 16; the 17th push sets overflow=1.
  - After TREADY=1, exactly 16 words drain in order, and TLAST positions still match the geometry (dropped pixels counted).
- FIFO full, push and pop in the same cycle: count stays 16, no overflow, the new pixel appears as the last word.
- TREADY toggled 1010… during a stall: TDATA, TLAST and TUSER stay constant whenever TVALID=1 && TREADY=0. Checked with an assertion every cycle.
- rst asserted for 1 cycle after 5 pixels of a 4x2 frame:
  - Next cycle: TVALID=0, overflow=0, upstream_ready=0.
  - Cycle after: upstream_ready=1.
  - The next push is tagged TUSER=1.
- Empty FIFO, single push: TVALID=1 exactly one cycle later; with TREADY=1, TVALID returns to 0 the following cycle and count=0.

Source files
------------

// File: rtl/haze_pkg.sv
// Definitions shared by the dehaze pipeline blocks: pixel/entry layout,
// default frame geometry and a constant-evaluable clog2.
package haze_pkg;

    localparam int PIXEL_W = 24;
    localparam int SOF_BIT = 24;
    localparam int EOL_BIT = 25;
    localparam int EOF_BIT = 26;
    localparam int ENTRY_W = 27;

    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The caller must never push while
// full unless it pops in the same cycle; there is no drop policy here.
import haze_pkg::*;

module sync_fifo_fwft #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_output_packer.sv
// Buffers dehazed RGB pixels and presents them as an AXI4-Stream master with
// frame geometry tags, an almost-full throttle and a sticky overflow flag.
import haze_pkg::*;

module axis_output_packer #(
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        upstream_ready,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,
    output logic        frame_done,
    output logic        overflow
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = (clog2(IMG_WIDTH)  < 1) ? 1 : clog2(IMG_WIDTH);
    localparam int RW = (clog2(IMG_HEIGHT) < 1) ? 1 : clog2(IMG_HEIGHT);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               eol;
    logic               sof;
    logic               eof;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW:0]        fifo_count;
    logic [AW:0]        count_next;
    logic               push;
    logic               pop;

    assign sof   = (col == '0) && (row == '0);
    assign eol   = (col == CW'(IMG_WIDTH - 1));
    assign eof   = eol && (row == RW'(IMG_HEIGHT - 1));
    assign entry = {eof, eol, sof, pix_r, pix_g, pix_b};

    // Handshake: a word transfers on every rising edge where TVALID && TREADY;
    // TVALID never waits on TREADY, and the word is held until it transfers.
    // The producer side has no handshake: pix_valid is an unconditional push.
    assign pop  = !fifo_empty && M_AXIS_TREADY;
    assign push = pix_valid && (!fifo_full || pop);

    assign count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head fields are masked while empty so an idle stream drives zeros.
    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? {8'h00, head[PIXEL_W-1:0]} : 32'h0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && head[EOL_BIT];
    assign M_AXIS_TUSER  = M_AXIS_TVALID && head[SOF_BIT];

    // Geometry counters advance on every pixel, dropped or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            overflow       <= 1'b0;
            upstream_ready <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            if (pix_valid) begin
                if (eol) begin
                    col <= '0;
                    row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (pix_valid && fifo_full && !pop) overflow <= 1'b1;
            upstream_ready <= (FIFO_DEPTH - int'(count_next)) > AFULL_MARGIN;
            frame_done     <= pop && head[EOF_BIT];
        end
    end

endmodule

// File: tb/tb_axis_output_packer.sv
// Bench for axis_output_packer on a 4x2 frame with a 16-entry FIFO: queue
// model, per-cycle compare, hold-stability assertion and literal pins.
module tb_axis_output_packer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 16;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_r = 8'h0;
    logic [7:0]  pix_g = 8'h0;
    logic [7:0]  pix_b = 8'h0;
    logic        tready = 1'b0;
    logic        upstream_ready;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TUSER;
    logic        frame_done;
    logic        overflow;

    axis_output_packer #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .FIFO_DEPTH   (D),
        .AFULL_MARGIN (M)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_valid      (pix_valid),
        .pix_r          (pix_r),
        .pix_g          (pix_g),
        .pix_b          (pix_b),
        .upstream_ready (upstream_ready),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TREADY  (tready),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .M_AXIS_TUSER   (M_AXIS_TUSER),
        .frame_done     (frame_done),
        .overflow       (overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected FIFO contents as {eof, eol, sof, R, G, B}
    logic [26:0] exp_q[$];
    int          pix_idx = 0;
    bit          ovf_m = 1'b0;
    bit          rdy_m = 1'b0;
    bit          fd_m  = 1'b0;
    bit          started = 1'b0;
    bit          hold_flag = 1'b0;
    logic [33:0] hold_val = '0;
    logic [33:0] acc_q[$];      // accepted words as {tlast, tuser, tdata}
    int          fd_count = 0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    always @(posedge clk) begin
        logic [26:0] e;
        int          col;
        int          row;
        bit          popped;
        started = 1'b1;
        if (rst) begin
            exp_q.delete();
            pix_idx   = 0;
            ovf_m     = 1'b0;
            rdy_m     = 1'b0;
            fd_m      = 1'b0;
            hold_flag = 1'b0;
        end else begin
            hold_flag = M_AXIS_TVALID && !tready;
            hold_val  = {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA};
            if (M_AXIS_TVALID && tready)
                acc_q.push_back({M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA});
            popped = (exp_q.size() > 0) && tready;
            fd_m   = 1'b0;
            if (popped) begin
                e    = exp_q.pop_front();
                fd_m = e[26];
            end
            if (pix_valid) begin
                col = pix_idx % W;
                row = pix_idx / W;
                e = {(col == W-1) && (row == H-1), col == W-1, (col == 0) && (row == 0),
                     pix_r, pix_g, pix_b};
                if (exp_q.size() < D) exp_q.push_back(e);
                else ovf_m = 1'b1;
                pix_idx = (pix_idx + 1) % (W * H);
            end
            rdy_m = (D - exp_q.size()) > M;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [26:0] h;
        bit          v;
        if (started) begin
            v = (exp_q.size() != 0);
            h = v ? exp_q[0] : 27'h0;
            check("tvalid", 34'(M_AXIS_TVALID), 34'(v));
            check("tdata", 34'(M_AXIS_TDATA), 34'({8'h00, h[23:0]}));
            check("tlast", 34'(M_AXIS_TLAST), 34'(h[25]));
            check("tuser", 34'(M_AXIS_TUSER), 34'(h[24]));
            check("upstream_ready", 34'(upstream_ready), 34'(rdy_m));
            check("overflow", 34'(overflow), 34'(ovf_m));
            check("frame_done", 34'(frame_done), 34'(fd_m));
            if (frame_done) fd_count++;
            if (hold_flag) begin
                checks++;
                assert ({M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA} == hold_val)
                else begin
                    failures++;
                    $display("FAIL hold_stable actual=%h expected=%h at %0t",
                             {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA}, hold_val, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic v, input logic [23:0] px, input logic tr);
        @(negedge clk);
        #1;
        rst       = r;
        pix_valid = v;
        {pix_r, pix_g, pix_b} = px;
        tready    = tr;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          base;
        int          fd0;
        logic [7:0]  b8;

        step(1'b1, 1'b0, 24'h0, 1'b0);
        step(1'b1, 1'b0, 24'h0, 1'b0);

        // Two back-to-back 4x2 frames with TREADY held high
        step(1'b0, 1'b0, 24'h0, 1'b1);
        base = acc_q.size();
        fd0  = fd_count;
        for (int i = 0; i < 16; i++) begin
            b8 = 8'(i % 8);
            step(1'b0, 1'b1, {b8, b8, b8}, 1'b1);
        end
        repeat (3) step(1'b0, 1'b0, 24'h0, 1'b1);
        check("frame_words", 34'(acc_q.size() - base), 34'd16);
        check("word0", acc_q[base + 0], 34'h1_00000000);
        check("word3", acc_q[base + 3], 34'h2_00030303);
        check("word7", acc_q[base + 7], 34'h2_00070707);
        check("word8", acc_q[base + 8], 34'h1_00000000);
        check("word15", acc_q[base + 15], 34'h2_00070707);
        check("frame_done_count", 34'(fd_count - fd0), 34'd2);

        // Stall with continuous pushes: throttle, saturate, overflow, drain
        step(1'b1, 1'b0, 24'h0, 1'b0);
        base = acc_q.size();
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 24'($urandom), 1'b0);
            settle();
            if (k == 11) check("ready_at_11", 34'(upstream_ready), 34'd1);
            if (k == 12) check("ready_at_12", 34'(upstream_ready), 34'd0);
            if (k == 16) check("ovf_at_16", 34'(overflow), 34'd0);
            if (k == 17) check("ovf_at_17", 34'(overflow), 34'd1);
        end
        repeat (20) step(1'b0, 1'b0, 24'h0, 1'b1);
        check("drain_words", 34'(acc_q.size() - base), 34'd16);
        check("drain_tuser0", 34'(acc_q[base][32]), 34'd1);
        check("drain_tlast3", 34'(acc_q[base + 3][33]), 34'd1);
        check("drain_tlast14", 34'(acc_q[base + 14][33]), 34'd0);
        check("drain_tlast15", 34'(acc_q[base + 15][33]), 34'd1);

        // Full FIFO with push and pop in the same cycle
        step(1'b1, 1'b0, 24'h0, 1'b0);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 24'($urandom), 1'b0);
        base = acc_q.size();
        step(1'b0, 1'b1, 24'hABCDEF, 1'b1);
        settle();
        check("full_pushpop_ovf", 34'(overflow), 34'd0);
        repeat (20) step(1'b0, 1'b0, 24'h0, 1'b1);
        check("full_pushpop_words", 34'(acc_q.size() - base), 34'd17);
        check("full_pushpop_last", 34'(acc_q[acc_q.size() - 1][23:0]), 34'hABCDEF);
        check("full_pushpop_tuser", 34'(acc_q[acc_q.size() - 1][32]), 34'd1);

        // TREADY toggling 1010... with heavy pushes
        step(1'b1, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 60; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 24'($urandom), 1'(i % 2 == 0));

        // Reset mid-frame after five pixels
        step(1'b1, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 24'($urandom), 1'b0);
        step(1'b1, 1'b0, 24'h0, 1'b0);
        settle();
        check("rst_tvalid", 34'(M_AXIS_TVALID), 34'd0);
        check("rst_overflow", 34'(overflow), 34'd0);
        check("rst_ready", 34'(upstream_ready), 34'd0);
        step(1'b0, 1'b0, 24'h0, 1'b0);
        settle();
        check("post_rst_ready", 34'(upstream_ready), 34'd1);
        step(1'b0, 1'b1, 24'h123456, 1'b0);
        settle();
        check("post_rst_tuser", 34'(M_AXIS_TUSER), 34'd1);
        check("post_rst_tdata", 34'(M_AXIS_TDATA), 34'h00123456);

        // Single push into an empty FIFO
        step(1'b1, 1'b0, 24'h0, 1'b1);
        step(1'b0, 1'b0, 24'h0, 1'b1);
        step(1'b0, 1'b1, 24'h0A0B0C, 1'b1);
        settle();
        check("single_tvalid_n1", 34'(M_AXIS_TVALID), 34'd1);
        step(1'b0, 1'b0, 24'h0, 1'b1);
        settle();
        check("single_tvalid_n2", 34'(M_AXIS_TVALID), 34'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 2) != 0));
        repeat (24) step(1'b0, 1'b0, 24'h0, 1'b1);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
